// File: rtl/kernel_stream_sequencer.sv
// kernel_stream_sequencer: job-level controller for the 3x3 sliding-window kernel.
// Runs NUM_FRAMES frames per job. Each frame clears the kernel, streams exactly
// IMG_WIDHT*IMG_HEIGHT pixels into it and forwards the expected window results.
// Optional feature macro: SEQ_PIXEL_POS_EN adds dst_row/dst_col window-position outputs.
module kernel_stream_sequencer #(
    parameter int DATA_WIDHT    = 32,
    parameter int IMG_WIDHT     = 220,
    parameter int IMG_HEIGHT    = 220,
    parameter int KERNEL_SIZE   = 3,
    parameter int NUM_FRAMES    = 3,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic                                busy,
    output logic                                done,
    output logic [1:0]                          err_flags,
    output logic [$clog2(NUM_FRAMES+1)-1:0]     frame_idx,
    input  logic [DATA_WIDHT-1:0]               src_data,
    input  logic                                src_valid,
    output logic                                src_ready,
    output logic                                krn_clr,
    output logic [DATA_WIDHT-1:0]               krn_data_in,
    output logic                                krn_valid_in,
    input  logic [DATA_WIDHT-1:0]               krn_data_out,
    input  logic                                krn_valid_out,
    output logic [DATA_WIDHT-1:0]               dst_data,
    output logic                                dst_valid
`ifdef SEQ_PIXEL_POS_EN
    ,
    output logic [$clog2(IMG_HEIGHT-KERNEL_SIZE+1)-1:0] dst_row,
    output logic [$clog2(IMG_WIDHT-KERNEL_SIZE+1)-1:0]  dst_col
`endif
);

    localparam int OUT_W = IMG_WIDHT - KERNEL_SIZE + 1;
    localparam int OUT_H = IMG_HEIGHT - KERNEL_SIZE + 1;
    localparam int N_IN  = IMG_WIDHT * IMG_HEIGHT;
    localparam int N_OUT = OUT_W * OUT_H;
    localparam int IN_W  = $clog2(N_IN + 1);
    localparam int OC_W  = $clog2(N_OUT + 1);
    localparam int TMO_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam int FR_W  = $clog2(NUM_FRAMES + 1);

    localparam logic [IN_W-1:0]  N_IN_C       = IN_W'(N_IN);
    localparam logic [OC_W-1:0]  N_OUT_C      = OC_W'(N_OUT);
    localparam logic [TMO_W-1:0] TMO_C        = TMO_W'(DRAIN_TIMEOUT);
    localparam logic [FR_W-1:0]  LAST_FRAME_C = FR_W'(NUM_FRAMES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [FR_W-1:0]         frame_q, frame_d;
    logic [IN_W-1:0]         in_cnt_q, in_cnt_d;
    logic [OC_W-1:0]         out_cnt_q, out_cnt_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic [1:0]              err_q, err_d;
    logic [DATA_WIDHT-1:0]   krn_data_q, krn_data_d;
    logic                    krn_valid_q, krn_valid_d;
    logic [DATA_WIDHT-1:0]   dst_data_q, dst_data_d;
    logic                    dst_valid_q, dst_valid_d;
    logic                    hs;
    logic                    fwd;

    assign src_ready    = (state_q == S_FEED);
    assign krn_clr      = (state_q == S_CLEAR);
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign err_flags    = err_q;
    assign frame_idx    = frame_q;
    assign krn_data_in  = krn_data_q;
    assign krn_valid_in = krn_valid_q;
    assign dst_data     = dst_data_q;
    assign dst_valid    = dst_valid_q;

    // A pixel moves only in FEED; a result is forwarded only while the frame still expects one.
    assign hs  = src_ready && src_valid;
    assign fwd = krn_valid_out && (state_q inside {S_FEED, S_DRAIN, S_NEXT}) && (out_cnt_q < N_OUT_C);

    // Next-state logic: counters, error flags, datapath registers and FSM transitions.
    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        tmo_d       = '0;
        err_d       = err_q;
        krn_data_d  = krn_data_q;
        krn_valid_d = 1'b0;
        dst_data_d  = dst_data_q;
        dst_valid_d = 1'b0;

        if (hs) begin
            krn_valid_d = 1'b1;
            krn_data_d  = src_data;
            in_cnt_d    = in_cnt_q + IN_W'(1);
        end

        if (fwd) begin
            dst_valid_d = 1'b1;
            dst_data_d  = krn_data_out;
            out_cnt_d   = out_cnt_q + OC_W'(1);
        end

        if (krn_valid_out && !fwd) begin
            err_d[1] = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d   = '0;
                    frame_d = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                in_cnt_d  = '0;
                out_cnt_d = '0;
                state_d   = S_FEED;
            end
            S_FEED: begin
                if (hs && (in_cnt_d == N_IN_C)) begin
                    state_d = (out_cnt_q == N_OUT_C) ? S_NEXT : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_cnt_q == N_OUT_C) begin
                    state_d = S_NEXT;
                end else begin
                    tmo_d = krn_valid_out ? '0 : (tmo_q + TMO_W'(1));
                    if (tmo_d == TMO_C) begin
                        err_d[0] = 1'b1;
                        state_d  = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                if (frame_q == LAST_FRAME_C) begin
                    state_d = S_DONE;
                end else begin
                    frame_d = frame_q + FR_W'(1);
                    state_d = S_CLEAR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any job in flight without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            frame_q     <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            tmo_q       <= '0;
            err_q       <= '0;
            krn_data_q  <= '0;
            krn_valid_q <= 1'b0;
            dst_data_q  <= '0;
            dst_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            krn_data_q  <= krn_data_d;
            krn_valid_q <= krn_valid_d;
            dst_data_q  <= dst_data_d;
            dst_valid_q <= dst_valid_d;
        end
    end

`ifdef SEQ_PIXEL_POS_EN
    localparam int ROW_W = $clog2(OUT_H);
    localparam int COL_W = $clog2(OUT_W);

    logic [ROW_W-1:0] row_q, row_d, dst_row_q, dst_row_d;
    logic [COL_W-1:0] col_q, col_d, dst_col_q, dst_col_d;

    assign dst_row = dst_row_q;
    assign dst_col = dst_col_q;

    // row_q/col_q hold the window position of the next result; it is latched alongside dst_data.
    always_comb begin
        row_d     = row_q;
        col_d     = col_q;
        dst_row_d = dst_row_q;
        dst_col_d = dst_col_q;
        if (state_q == S_CLEAR) begin
            row_d = '0;
            col_d = '0;
        end else if (fwd) begin
            dst_row_d = row_q;
            dst_col_d = col_q;
            if (col_q == COL_W'(OUT_W - 1)) begin
                col_d = '0;
                row_d = (row_q == ROW_W'(OUT_H - 1)) ? '0 : (row_q + ROW_W'(1));
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q     <= '0;
            col_q     <= '0;
            dst_row_q <= '0;
            dst_col_q <= '0;
        end else begin
            row_q     <= row_d;
            col_q     <= col_d;
            dst_row_q <= dst_row_d;
            dst_col_q <= dst_col_d;
        end
    end
`endif

endmodule

// File: doc/kernel_stream_sequencer.md
Name: kernel_stream_sequencer

Overview:
Job-level controller that sequences the sliding-window convolution kernel (Kernel_3x3_stride_1x1 family) over NUM_FRAMES consecutive image frames (channels). It clears the kernel before each frame, streams exactly IMG_WIDHT*IMG_HEIGHT pixels from an upstream source into it, and counts the expected window outputs. It forwards those outputs downstream, reports start/busy/done and sticky error flags, and sits between the pixel DMA/FIFO and the kernel instance.

Parameters:
DATA_WIDHT, 32, pixel/result word width
IMG_WIDHT, 220, input frame width in pixels
IMG_HEIGHT, 220, input frame height in pixels
KERNEL_SIZE, 3, square window size; stride fixed at 1
NUM_FRAMES, 3, frames per job
DRAIN_TIMEOUT, 1024, max cycles in DRAIN without a kernel output before abort of that frame

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  job start pulse; ignored unless IDLE
busy  out  1  high from the cycle after start accepted until DONE exits
done  out  1  one-cycle pulse at job end
err_flags  out  2  bit0 drain timeout, bit1 overrun/spurious output; sticky until next accepted start
frame_idx  out  $clog2(NUM_FRAMES+1)  current frame number, 0-based
src_data  in  DATA_WIDHT  upstream pixel
src_valid  in  1  upstream pixel valid
src_ready  out  1  sequencer accepts pixel
krn_clr  out  1  one-cycle active-high kernel line-buffer clear
krn_data_in  out  DATA_WIDHT  pixel to kernel
krn_valid_in  out  1  kernel input qualifier
krn_data_out  in  DATA_WIDHT  kernel result
krn_valid_out  in  1  kernel result valid
dst_data  out  DATA_WIDHT  forwarded result
dst_valid  out  1  forwarded result valid (no backpressure)

Behaviour:
- Reset: state IDLE; all outputs 0; all counters 0; err_flags 0. Reset mid-job aborts immediately, with no done pulse.
- Derived: OUT_W=IMG_WIDHT-KERNEL_SIZE+1, OUT_H=IMG_HEIGHT-KERNEL_SIZE+1, N_IN=IMG_WIDHT*IMG_HEIGHT, N_OUT=OUT_W*OUT_H. Counter widths are $clog2(N+1) and must not wrap.
- FSM:
  - IDLE: start=1 clears err_flags and frame_idx, then goes to CLEAR.
  - CLEAR (1 cycle): krn_clr=1, in_cnt=out_cnt=0, then FEED.
  - FEED: src_ready=1. Handshake is src_valid&src_ready; in_cnt increments on each handshake. On the handshake that makes in_cnt=N_IN, go to DRAIN, or to NEXT if out_cnt already equals N_OUT.
  - DRAIN: src_ready=0. Wait until out_cnt=N_OUT, then NEXT. The timeout counter resets on every krn_valid_out; reaching DRAIN_TIMEOUT sets err_flags[0] and goes to NEXT.
  - NEXT (1 cycle): if frame_idx=NUM_FRAMES-1 go to DONE, else frame_idx+1 and CLEAR.
  - DONE (1 cycle): done=1, then IDLE.
- Input path: krn_data_in/krn_valid_in are registered from a handshake, so latency is 1 cycle. Gaps in src_valid produce gaps in krn_valid_in. krn_data_in holds its last value when krn_valid_in=0.
- Output path: dst_data/dst_valid are registered from krn_data_out/krn_valid_out, latency 1 cycle. Forwarding happens only in FEED/DRAIN/NEXT and only while out_cnt<N_OUT; each forward increments out_cnt.
- A krn_valid_out when out_cnt=N_OUT, or in IDLE/CLEAR/DONE, is dropped (dst_valid=0) and sets err_flags[1].
- busy is 0 in IDLE, 1 in all other states.
- Simultaneous last input handshake and kernel output in the same cycle: both are counted.

Optional Feature:
SEQ_PIXEL_POS_EN: when defined, adds outputs dst_row and dst_col ($clog2(OUT_H), $clog2(OUT_W)), registered with dst_data. They give the output-window position: col increments per forwarded result and wraps at OUT_W-1, where row increments. Both reset to 0 at CLEAR. When undefined, these ports and their counters are absent and behaviour is otherwise identical.

Test Plan:
- IMG 5x5, KERNEL_SIZE 3, NUM_FRAMES 2, behavioural kernel model, src_valid always 1. Start -> krn_clr pulses twice, 25 krn_valid_in per frame, 9 dst_valid per frame, frame_idx 0->1, single done pulse, err_flags=0.
- Same config, src_valid toggling 1/0 -> 25 handshakes per frame, krn_valid_in gaps mirror the src gaps, 9 outputs per frame, done pulse.
- Kernel model emits 10 outputs in frame 0 -> 9 forwarded, err_flags=2'b10, job still completes.
- Kernel model emits 7 outputs, DRAIN_TIMEOUT 16 -> DRAIN exits 16 cycles after the last output, err_flags[0]=1, frame 1 proceeds.
- Assert rst during FEED of frame 1 -> next edge: busy=0, src_ready=0, all outputs 0, no done. A later start runs a clean job.
- start pulsed while busy -> ignored, frame_idx and counts unaffected. With SEQ_PIXEL_POS_EN: ninth output carries row=2, col=2.
